id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register sitting directly downstream of the register file.
- Captures both register-file read ports plus decoded fields, and bypasses the same-cycle writeback, since the register file writes on the clock edge and reads combinationally.
- Detects load-use hazards, inserts bubbles, and honours flush/hold from branch and memory logic.

Parameters:
- XLEN, 64, datapath width
- REG_ADDR_W, 5, register index width
- CTRL_W, 8, decoded control bundle width (bit map in package)

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode slot holds a real instruction
- in_pc  in  XLEN  decode PC
- in_imm  in  XLEN  sign-extended immediate
- in_rs1, in_rs2  in  REG_ADDR_W  source indices (also drive register file rs1/rs2)
- in_uses_rs1, in_uses_rs2  in  1  instruction actually reads that source
- in_rd  in  REG_ADDR_W  destination index
- in_ctrl  in  CTRL_W  decoded control bundle
- rf_rd1, rf_rd2  in  XLEN  register file Read_Data_1/2
- wb_regwrite  in  1  writeback enable (same signal as register file RegWrite)
- wb_rd  in  REG_ADDR_W  writeback destination
- wb_data  in  XLEN  writeback data
- flush  in  1  branch/jump redirect kills decode slot
- hold  in  1  downstream stall; freeze this register
- load_use_stall  out  1  combinational; upstream PC and IF/ID must hold
- ex_valid  out  1  execute slot valid
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN  registered operands
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  registered indices (for EX forwarding)
- ex_ctrl  out  CTRL_W  registered control; all-zero NOP when invalid

Behaviour:
- Reset is synchronous. On the edge with reset=1, all ex_* outputs clear to 0, including ex_valid.
- load_use_stall = in_valid & ex_valid & ex_ctrl[MEMREAD] & (ex_rd!=0) & ((in_uses_rs1 & ex_rd==in_rs1) | (in_uses_rs2 & ex_rd==in_rs2)) & ~flush & ~hold.
- Operand select, per source, evaluated in this order:
  - index 0 → 0. x0 is forced to zero here regardless of register file contents.
  - else wb_regwrite & wb_rd==index → wb_data (write-first bypass).
  - else rf_rdN.
- Edge priority is reset > flush > hold > load_use_stall > load:
  - flush: ex_valid<=0, ex_ctrl<=0. Other fields are don't-care and hold their value.
  - hold: all ex_* unchanged. load_use_stall is forced 0.
  - load_use_stall: bubble, i.e. ex_valid<=0 and ex_ctrl<=0. The decode slot re-presents next cycle and the stall drops automatically, so the stall lasts exactly 1 cycle per hazard.
  - load: ex_valid<=in_valid. All fields capture. ex_ctrl<=in_valid ? in_ctrl : 0.
- Latency is 1 cycle from decode to execute.
- No state machine beyond the valid bit.
- flush and load_use_stall in the same cycle: flush wins and no stall is asserted.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - Two 32-bit outputs are added: perf_bubbles (counts cycles a load-use bubble is inserted) and perf_flushes (counts cycles flush=1 while in_valid=1).
  - Both counters wrap at 2^32.
  - Both clear on reset.
  - Neither counter increments while hold=1.
- When undefined: the ports and counters are absent, and functional behaviour is identical.

Decomposition:
- Package riscv_pipe_pkg holds:
  - XLEN and REG_ADDR_W.
  - ctrl bit indices REGWRITE=0, MEMREAD=1, MEMWRITE=2, MEMTOREG=3, ALUSRC=4, BRANCH=5, ALUOP=7:6.
  - CTRL_NOP=0.
- One sub-module, operand_bypass: purely combinational x0/writeback/register-file select, instantiated twice (rs1 and rs2).

Test Plan:
- Simple load: in_valid=1, rs1=3, rs2=4, rf_rd1=0x11, rf_rd2=0x22, no writeback → next cycle ex_valid=1, ex_rs1_data=0x11, ex_rs2_data=0x22, ex_ctrl=in_ctrl.
- Writeback bypass: wb_regwrite=1, wb_rd=3, wb_data=0xDEAD, in_rs1=3, rf_rd1 stale 0x11 → ex_rs1_data=0xDEAD. Repeat with wb_rd=0 and in_rs1=0 → ex_rs1_data=0.
- Load-use: EX holds ld x5 (MEMREAD=1, ex_rd=5); decode add using rs2=5 → load_use_stall=1 for exactly one cycle, then ex_valid=0 and ex_ctrl=0. Next cycle the add loads normally. The same case with in_uses_rs2=0 → no stall.
- Flush over stall: load-use condition plus flush=1 → load_use_stall=0, ex_valid=0 next cycle. With ID_EX_PERF_CNT_EN defined, perf_flushes increments by 1.
- Hold: valid instruction in EX, hold=1 for 3 cycles with changing inputs → all ex_* outputs stable. On release, the current decode slot is captured.
- Reset mid-stream: reset=1 while ex_valid=1 and load_use_stall=1 → after the edge, all ex_* are 0 and load_use_stall=0. With ID_EX_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg
//   Shared pipeline constants: datapath/register-index widths, the bit map of
//   the decoded control bundle, and the all-zero NOP control value.
package riscv_pipe_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 8;

  // Decoded control bundle bit map
  localparam int REGWRITE  = 0;
  localparam int MEMREAD   = 1;
  localparam int MEMWRITE  = 2;
  localparam int MEMTOREG  = 3;
  localparam int ALUSRC    = 4;
  localparam int BRANCH    = 5;
  localparam int ALUOP_LSB = 6;
  localparam int ALUOP_MSB = 7;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_operand_bypass.sv
// operand_bypass
//   Purely combinational source-operand select feeding the ID/EX register.
//   Priority: x0 reads as zero, then the same-cycle writeback value (the
//   register file writes on the clock edge, so its read port is still stale
//   during this cycle), then the register file read data.
// Ports:
//   idx         source register index
//   rf_data     register file read data for this source
//   wb_regwrite writeback enable
//   wb_rd       writeback destination index
//   wb_data     writeback data
//   operand     selected operand value
module operand_bypass #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] idx,
  input  logic [XLEN-1:0]       rf_data,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       operand
);

  always_comb begin
    operand = rf_data;
    if (idx == '0) begin
      operand = '0;
    end else if (wb_regwrite && (wb_rd == idx)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//   Decode-to-execute pipeline register. Captures both register-file read
//   ports (with x0 forcing and write-first writeback bypass) and the decoded
//   fields, detects load-use hazards against the instruction in EX and
//   inserts a one-cycle bubble, and honours flush/hold.
//   Edge priority: reset > flush > hold > load_use_stall > load.
//   Optional feature macro: ID_EX_PERF_CNT_EN adds perf_bubbles/perf_flushes.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_*                   decode slot: valid, pc, imm, sources, dest, ctrl
//   rf_rd1, rf_rd2         register file read data
//   wb_regwrite/rd/data    writeback port (same as register file write)
//   flush, hold            redirect kill / downstream freeze
//   load_use_stall         combinational; upstream PC and IF/ID must hold
//   ex_*                   registered execute slot
//   perf_bubbles/flushes   (macro only) 32-bit wrapping event counters
module id_ex_stage_reg #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic                  in_uses_rs1,
  input  logic                  in_uses_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [XLEN-1:0]       rf_rd1,
  input  logic [XLEN-1:0]       rf_rd2,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  load_use_stall,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_flushes,
`endif
  output logic [CTRL_W-1:0]     ex_ctrl
);

  import riscv_pipe_pkg::*;

  logic                  ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]       ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]       ex_imm_q, ex_imm_d;
  logic [XLEN-1:0]       ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]       ex_rs2_data_q, ex_rs2_data_d;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0]     ex_ctrl_q, ex_ctrl_d;

  logic [XLEN-1:0] op1, op2;
  logic            hazard;
  logic            stall;

  operand_bypass #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_bypass_rs1 (
    .idx        (in_rs1),
    .rf_data    (rf_rd1),
    .wb_regwrite(wb_regwrite),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .operand    (op1)
  );

  operand_bypass #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_bypass_rs2 (
    .idx        (in_rs2),
    .rf_data    (rf_rd2),
    .wb_regwrite(wb_regwrite),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .operand    (op2)
  );

  // A load in EX whose destination a real decode-slot source reads. Flush
  // kills the slot anyway and hold freezes everything, so neither stalls.
  always_comb begin
    hazard = in_valid && ex_valid_q && ex_ctrl_q[MEMREAD] && (ex_rd_q != '0) &&
             ((in_uses_rs1 && (ex_rd_q == in_rs1)) ||
              (in_uses_rs2 && (ex_rd_q == in_rs2)));
    stall  = hazard && !flush && !hold;
  end

  assign load_use_stall = stall;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_ctrl_d     = ex_ctrl_q;
    if (flush || (!hold && stall)) begin
      // Kill or bubble: only valid and control matter, data fields keep value.
      ex_valid_d = 1'b0;
      ex_ctrl_d  = CTRL_NOP;
    end else if (!hold) begin
      ex_valid_d    = in_valid;
      ex_pc_d       = in_pc;
      ex_imm_d      = in_imm;
      ex_rs1_data_d = op1;
      ex_rs2_data_d = op2;
      ex_rs1_d      = in_rs1;
      ex_rs2_d      = in_rs2;
      ex_rd_d       = in_rd;
      ex_ctrl_d     = in_valid ? in_ctrl : CTRL_NOP;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_imm_q      <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_ctrl_q     <= CTRL_NOP;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_ctrl_q     <= ex_ctrl_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_ctrl     = ex_ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  // stall already excludes hold; flushes are gated explicitly. Both wrap.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_flushes_d = perf_flushes_q;
    if (stall) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
    if (flush && in_valid && !hold) begin
      perf_flushes_d = perf_flushes_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_bubbles_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg
//   Self-checking bench for id_ex_stage_reg. A reference model predicts the
//   execute slot for every cycle; predictions are queued when inputs are
//   driven and compared after the clock edge. Directed cases follow the
//   design's key scenarios, then a randomized stretch. Also builds with
//   ID_EX_PERF_CNT_EN defined.
module tb_id_ex_stage_reg;
  import riscv_pipe_pkg::*;

  localparam int EW = 1 + 4*XLEN + 3*REG_ADDR_W + CTRL_W;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic [XLEN-1:0]       in_pc, in_imm;
  logic [REG_ADDR_W-1:0] in_rs1, in_rs2, in_rd;
  logic                  in_uses_rs1, in_uses_rs2;
  logic [CTRL_W-1:0]     in_ctrl;
  logic [XLEN-1:0]       rf_rd1, rf_rd2;
  logic                  wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  flush, hold;
  logic                  load_use_stall;
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0]     ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]           perf_bubbles, perf_flushes;
  logic [31:0]           m_bub, m_fl;
`endif

  // ---------------- clock/reset block ----------------
  always #5 clock = ~clock;

  id_ex_stage_reg dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_uses_rs1   (in_uses_rs1),
    .in_uses_rs2   (in_uses_rs2),
    .in_rd         (in_rd),
    .in_ctrl       (in_ctrl),
    .rf_rd1        (rf_rd1),
    .rf_rd2        (rf_rd2),
    .wb_regwrite   (wb_regwrite),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .flush         (flush),
    .hold          (hold),
    .load_use_stall(load_use_stall),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_rs1_data   (ex_rs1_data),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
`ifdef ID_EX_PERF_CNT_EN
    .perf_bubbles  (perf_bubbles),
    .perf_flushes  (perf_flushes),
`endif
    .ex_ctrl       (ex_ctrl)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  logic                  m_valid;
  logic [XLEN-1:0]       m_pc, m_imm, m_d1, m_d2;
  logic [REG_ADDR_W-1:0] m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0]     m_ctrl;

  task automatic check_val(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_operand(input logic [REG_ADDR_W-1:0] idx,
                                                  input logic [XLEN-1:0] rf);
    if (idx == 0) return '0;
    if (wb_regwrite && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    return {ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_ctrl};
  endfunction

  task automatic model_clear();
    m_valid = 0; m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
`ifdef ID_EX_PERF_CNT_EN
    m_bub = '0; m_fl = '0;
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    reset = 0; in_valid = 0; in_pc = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_uses_rs1 = 0; in_uses_rs2 = 0;
    in_ctrl = '0; rf_rd1 = '0; rf_rd2 = '0;
    wb_regwrite = 0; wb_rd = '0; wb_data = '0; flush = 0; hold = 0;
  endtask

  task automatic set_instr(input logic [REG_ADDR_W-1:0] rs1, input logic [REG_ADDR_W-1:0] rs2,
                           input logic u1, input logic u2,
                           input logic [REG_ADDR_W-1:0] rd, input logic [CTRL_W-1:0] ctrl);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_uses_rs1 = u1; in_uses_rs2 = u2;
    in_rd = rd; in_ctrl = ctrl;
    in_pc = {$urandom, $urandom}; in_imm = {$urandom, $urandom};
    rf_rd1 = {$urandom, $urandom}; rf_rd2 = {$urandom, $urandom};
  endtask

  // Inputs must already be applied. Checks the combinational stall, predicts
  // the next execute slot, clocks once and compares.
  task automatic step();
    logic          exp_stall;
    logic [EW-1:0] e;
    exp_stall = in_valid && m_valid && m_ctrl[MEMREAD] && (m_rd != 0) &&
                ((in_uses_rs1 && m_rd == in_rs1) || (in_uses_rs2 && m_rd == in_rs2)) &&
                !flush && !hold;
    #1;
    check_val("load_use_stall", EW'(load_use_stall), EW'(exp_stall));
    if (reset) begin
      model_clear();
    end else begin
`ifdef ID_EX_PERF_CNT_EN
      if (exp_stall) m_bub = m_bub + 1;
      if (flush && in_valid && !hold) m_fl = m_fl + 1;
`endif
      if (flush) begin
        m_valid = 0; m_ctrl = '0;
      end else if (hold) begin
        // frozen
      end else if (exp_stall) begin
        m_valid = 0; m_ctrl = '0;
      end else begin
        m_valid = in_valid; m_pc = in_pc; m_imm = in_imm;
        m_d1 = ref_operand(in_rs1, rf_rd1); m_d2 = ref_operand(in_rs2, rf_rd2);
        m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
        m_ctrl = in_valid ? in_ctrl : '0;
      end
    end
    exp_q.push_back({m_valid, m_pc, m_imm, m_d1, m_d2, m_rs1, m_rs2, m_rd, m_ctrl});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_val("ex_slot", dut_vec(), e);
`ifdef ID_EX_PERF_CNT_EN
    check_val("perf_bubbles", EW'(perf_bubbles), EW'(m_bub));
    check_val("perf_flushes", EW'(perf_flushes), EW'(m_fl));
`endif
  endtask

  localparam logic [CTRL_W-1:0] C_LD  = 8'h0B; // regwrite, memread, memtoreg
  localparam logic [CTRL_W-1:0] C_ADD = 8'h81; // regwrite, aluop=2

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    reset = 1;
    @(posedge clock); #1;
    model_clear();
    step();                                   // reset state
    check_val("reset_valid", EW'(ex_valid), EW'(0));
    reset = 0;

    // simple load
    set_instr(5'd3, 5'd4, 1, 1, 5'd7, C_ADD);
    rf_rd1 = 64'h11; rf_rd2 = 64'h22;
    step();
    check_val("simple_valid", EW'(ex_valid), EW'(1));
    check_val("simple_rs1_data", EW'(ex_rs1_data), EW'(64'h11));
    check_val("simple_rs2_data", EW'(ex_rs2_data), EW'(64'h22));
    check_val("simple_ctrl", EW'(ex_ctrl), EW'(C_ADD));

    // writeback bypass, then x0 with writeback to x0
    set_instr(5'd3, 5'd4, 1, 1, 5'd8, C_ADD);
    rf_rd1 = 64'h11; wb_regwrite = 1; wb_rd = 5'd3; wb_data = 64'hDEAD;
    step();
    check_val("bypass_rs1_data", EW'(ex_rs1_data), EW'(64'hDEAD));
    set_instr(5'd0, 5'd4, 1, 1, 5'd8, C_ADD);
    rf_rd1 = 64'h11; wb_rd = 5'd0;
    step();
    check_val("x0_rs1_data", EW'(ex_rs1_data), EW'(0));
    wb_regwrite = 0;

    // load-use: ld x5 then add using rs2=x5
    set_instr(5'd1, 5'd2, 1, 0, 5'd5, C_LD);
    step();
    set_instr(5'd1, 5'd5, 1, 1, 5'd6, C_ADD);
    #1 check_val("lu_stall_high", EW'(load_use_stall), EW'(1));
    step();
    check_val("lu_bubble_valid", EW'(ex_valid), EW'(0));
    check_val("lu_bubble_ctrl", EW'(ex_ctrl), EW'(0));
    check_val("lu_stall_dropped", EW'(load_use_stall), EW'(0));
    step();
    check_val("lu_add_valid", EW'(ex_valid), EW'(1));
    check_val("lu_add_rd", EW'(ex_rd), EW'(6));

    // same but rs2 not used: no stall
    set_instr(5'd1, 5'd2, 1, 0, 5'd5, C_LD);
    step();
    set_instr(5'd1, 5'd5, 1, 0, 5'd6, C_ADD);
    #1 check_val("lu_unused_no_stall", EW'(load_use_stall), EW'(0));
    step();

    // flush over stall
    set_instr(5'd1, 5'd2, 1, 0, 5'd5, C_LD);
    step();
    set_instr(5'd5, 5'd2, 1, 1, 5'd6, C_ADD);
    flush = 1;
    #1 check_val("flush_no_stall", EW'(load_use_stall), EW'(0));
    step();
    check_val("flush_valid", EW'(ex_valid), EW'(0));
    flush = 0;

    // hold for 3 cycles with changing inputs, then release
    set_instr(5'd9, 5'd10, 1, 1, 5'd11, C_ADD);
    step();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 1,
                5'($urandom_range(0, 31)), 8'($urandom));
      step();
      check_val("hold_rd_stable", EW'(ex_rd), EW'(11));
    end
    hold = 0;
    step();

    // reset mid-stream with a stall pending
    set_instr(5'd1, 5'd2, 1, 0, 5'd5, C_LD);
    step();
    set_instr(5'd5, 5'd2, 1, 1, 5'd6, C_ADD);
    #1 check_val("rst_pre_stall", EW'(load_use_stall), EW'(1));
    reset = 1;
    step();
    check_val("rst_slot_zero", dut_vec(), '0);
    check_val("rst_stall_low", EW'(load_use_stall), EW'(0));
    reset = 0;

    // randomized stretch with small register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 8'($urandom));
      in_valid    = ($urandom_range(0, 7) != 0);
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = {$urandom, $urandom};
      flush       = ($urandom_range(0, 7) == 0);
      hold        = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
